// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - state type, limits and elaboration-time transition function for seq_detect_moore
package seq_det_pkg;

  localparam int MAX_SEQ_LEN = 8;

  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
    S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8
  } state_t;

  // pattern is right-aligned: pattern[len-1] is the first bit received.
  // Returns the longest prefix of the pattern that is a suffix of (prefix_k, a).
  function automatic state_t next_state(input logic [MAX_SEQ_LEN-1:0] pattern,
                                        input int len, input bit overlap,
                                        input int k, input logic a);
    int         kk;
    int         idx;
    logic [3:0] res;
    logic [2:0] pidx;
    logic       sb;
    bit         ok;
    if (k < 0 || k > len) return S0;
    kk  = (k == len && !overlap) ? 0 : k;
    res = 4'd0;
    for (int j = 1; j <= MAX_SEQ_LEN; j++) begin
      if (j <= kk + 1 && j <= len) begin
        ok = 1'b1;
        for (int m = 0; m < MAX_SEQ_LEN; m++) begin
          if (m < j) begin
            idx = kk + 1 - j + m;
            if (idx == kk) begin
              sb = a;
            end else begin
              pidx = 3'(len - 1 - idx);
              sb   = pattern[pidx];
            end
            pidx = 3'(len - 1 - m);
            if (sb != pattern[pidx]) ok = 1'b0;
          end
        end
        if (ok) res = 4'(j);
      end
    end
    return state_t'(res);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != {CNT_W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_moore.sv
// rtl/seq_detect_moore.sv - Moore serial pattern detector with saturating match counter
module seq_detect_moore
  import seq_det_pkg::*;
#(
  parameter int               SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             A,
  input  logic             clr_cnt,
  output logic             Y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [3:0]       state_o
);

  localparam int                     NUM_CODES = 16;
  localparam logic [MAX_SEQ_LEN-1:0] PAT_EXT   = MAX_SEQ_LEN'(PATTERN);
  localparam state_t                 S_MATCH   = state_t'(SEQ_LEN);

  state_t state_q, state_d;
  state_t trans_tbl [NUM_CODES][2];
  logic   hit;

  // Full transition table is a constant; codes above SEQ_LEN fall back to S0.
  for (genvar k = 0; k < NUM_CODES; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_in
      localparam state_t NXT = next_state(PAT_EXT, SEQ_LEN, OVERLAP, k, 1'(b));
      assign trans_tbl[k][b] = NXT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (en) begin
      state_d = trans_tbl[state_q][A];
      hit     = (state_d == S_MATCH);
    end
  end

  assign Y       = (state_q == S_MATCH);
  assign state_o = state_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr_cnt),
    .inc  (hit),
    .count(match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_moore.sv
// tb/tb_seq_detect_moore.sv - self-checking bench for seq_detect_moore over four parameter sets
module tb_seq_detect_moore;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic A = 1'b0;
  logic clr_cnt = 1'b0;

  logic y0, y1, y2, y3;
  logic [3:0] s0, s1, s2, s3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  int n_cmp = 0;
  int n_fail = 0;

  int         cfg_len [4] = '{4, 4, 2, 1};
  logic [7:0] cfg_pat [4] = '{8'b1011, 8'b1011, 8'b01, 8'b1};
  bit         cfg_ovl [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int         cfg_max [4] = '{255, 255, 255, 3};

  logic [7:0] hist [4];
  int nv [4];
  int mstate [4];
  int mcnt [4];

  always #5 clk = ~clk;

  seq_detect_moore u_def (
    .clk(clk), .reset(reset), .en(en), .A(A), .clr_cnt(clr_cnt),
    .Y(y0), .match_cnt(c0), .state_o(s0));

  seq_detect_moore #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .reset(reset), .en(en), .A(A), .clr_cnt(clr_cnt),
    .Y(y1), .match_cnt(c1), .state_o(s1));

  seq_detect_moore #(.SEQ_LEN(2), .PATTERN(2'b01)) u_len2 (
    .clk(clk), .reset(reset), .en(en), .A(A), .clr_cnt(clr_cnt),
    .Y(y2), .match_cnt(c2), .state_o(s2));

  seq_detect_moore #(.SEQ_LEN(1), .PATTERN(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .A(A), .clr_cnt(clr_cnt),
    .Y(y3), .match_cnt(c3), .state_o(s3));

  function automatic logic [15:0] get_y(input int i);
    case (i)
      0: return 16'(y0);
      1: return 16'(y1);
      2: return 16'(y2);
      default: return 16'(y3);
    endcase
  endfunction

  function automatic logic [15:0] get_s(input int i);
    case (i)
      0: return 16'(s0);
      1: return 16'(s1);
      2: return 16'(s2);
      default: return 16'(s3);
    endcase
  endfunction

  function automatic logic [15:0] get_c(input int i);
    case (i)
      0: return 16'(c0);
      1: return 16'(c1);
      2: return 16'(c2);
      default: return 16'(c3);
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Longest pattern prefix matching the tail of the accepted history.
  function automatic int longest(input int i);
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j <= 8; j++) begin
      if (j <= cfg_len[i] && j <= nv[i]) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++)
          if (hist[i][j-1-m] != cfg_pat[i][cfg_len[i]-1-m]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist[i] = '0;
      nv[i] = 0;
      mstate[i] = 0;
      mcnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      if (en) begin
        hist[i] = {hist[i][6:0], A};
        if (nv[i] < 8) nv[i]++;
        mstate[i] = longest(i);
        if (mstate[i] == cfg_len[i]) begin
          if (mcnt[i] < cfg_max[i]) mcnt[i]++;
          if (!cfg_ovl[i]) nv[i] = 0;
        end
      end
      if (clr_cnt) mcnt[i] = 0;
    end
  endtask

  task automatic tick(input logic a_i, input logic e_i, input logic c_i);
    A = a_i;
    en = e_i;
    clr_cnt = c_i;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Entered 1 time unit after a rising edge; reset pulse lies wholly between edges.
  task automatic pulse_reset(input bit chk);
    #1;
    reset = 1'b0;
    #2;
    if (chk) begin
      check("mid_rst_y", get_y(0), 16'd0);
      check("mid_rst_state", get_s(0), 16'd0);
      check("mid_rst_cnt", get_c(0), 16'd0);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic compare_model(input int i);
    check($sformatf("rand_y%0d", i), get_y(i), 16'(mstate[i] == cfg_len[i]));
    check($sformatf("rand_state%0d", i), get_s(i), 16'(mstate[i]));
    check($sformatf("rand_cnt%0d", i), get_c(i), 16'(mcnt[i]));
  endtask

  typedef struct {
    bit         rst;
    logic       a;
    logic       e;
    logic       c;
    logic       yd;
    logic [7:0] cd;
    logic       yn;
    logic [7:0] cn;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic exp_y2 [5];
    logic dat2 [5];
    logic [1:0] exp_c3 [5];

    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 8'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 8'd1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 8'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 8'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0});

    model_reset();
    #3;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_y%0d", i), get_y(i), 16'd0);
      check($sformatf("reset_state%0d", i), get_s(i), 16'd0);
      check($sformatf("reset_cnt%0d", i), get_c(i), 16'd0);
    end
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    foreach (vecs[v]) begin
      if (vecs[v].rst) pulse_reset(1'b0);
      tick(vecs[v].a, vecs[v].e, vecs[v].c);
      check($sformatf("vec%0d_y_def", v), get_y(0), 16'(vecs[v].yd));
      check($sformatf("vec%0d_cnt_def", v), get_c(0), 16'(vecs[v].cd));
      check($sformatf("vec%0d_y_novl", v), get_y(1), 16'(vecs[v].yn));
      check($sformatf("vec%0d_cnt_novl", v), get_c(1), 16'(vecs[v].cn));
    end

    dat2 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_y2 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pulse_reset(1'b0);
    for (int b = 0; b < 5; b++) begin
      tick(dat2[b], 1'b1, 1'b0);
      check($sformatf("len2_y_bit%0d", b), get_y(2), 16'(exp_y2[b]));
    end
    check("len2_cnt", get_c(2), 16'd2);

    exp_c3 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pulse_reset(1'b0);
    for (int b = 0; b < 5; b++) begin
      tick(1'b1, 1'b1, 1'b0);
      check($sformatf("sat_cnt_bit%0d", b), get_c(3), 16'(exp_c3[b]));
      check($sformatf("sat_y_bit%0d", b), get_y(3), 16'd1);
    end
    tick(1'b1, 1'b1, 1'b1);
    check("sat_clr_cnt", get_c(3), 16'd0);
    check("sat_clr_y", get_y(3), 16'd1);

    pulse_reset(1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("pre_rst_state", get_s(0), 16'd3);
    pulse_reset(1'b1);
    tick(1'b1, 1'b1, 1'b0);
    check("post_rst_y", get_y(0), 16'd0);
    check("post_rst_state", get_s(0), 16'd1);

    pulse_reset(1'b0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset(1'b0);
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0));
      for (int i = 0; i < 4; i++) compare_model(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
